// File: rtl/simplegrev.sv
// simplegrev: generalized-reverse (GREV) unit with one registered output stage.
//
// rs1 is permuted by a cascade of SHW conditional swap stages. Stage k, enabled by
// rs2[k], exchanges every pair of adjacent 2^k-bit blocks. This covers bit, nibble,
// byte and halfword reversals and swaps (rev, rev8, brev8, swap16). Fixed latency of
// one cycle, one operand pair per cycle, with no handshake.
//
// Ports:
//   clock   in   1     rising-edge clock
//   resetn  in   1     asynchronous active-low reset; clears rd
//   rs1     in   XLEN  source operand
//   rs2     in   SHW   GREV control; bit k enables stage k
//   rd      out  XLEN  registered result, grev(rs1, rs2) of the previous edge

module simplegrev #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [XLEN-1:0] rs1,
  input  logic [SHW-1:0]  rs2,
  output logic [XLEN-1:0] rd
);

  logic [XLEN-1:0] rd_d, rd_q;

  // Stage-k mask selects the lower block of each 2^k-bit pair: runs of 2^k ones
  // alternating with 2^k zeros, starting with ones at bit 0 (M0 = ...5555).
  function automatic logic [XLEN-1:0] grev_mask(input int unsigned k);
    logic [XLEN-1:0] m;
    for (int unsigned i = 0; i < XLEN; i++) begin
      m[i] = (((i >> k) & 1) == 0);
    end
    return m;
  endfunction

  // Swap cascade. Stages commute, so the fixed low-to-high order is arbitrary.
  always_comb begin
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] m;
    x = rs1;
    m = '0;
    for (int unsigned k = 0; k < SHW; k++) begin
      m = grev_mask(k);
      if (rs2[k]) begin
        x = ((x & m) << (1 << k)) | ((x >> (1 << k)) & m);
      end
    end
    rd_d = x;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd = rd_q;

endmodule

// File: tb/tb_simplegrev.sv
// tb_simplegrev: self-checking bench for simplegrev (XLEN = 32).
// Reference model uses the index form of GREV: result bit i = operand bit (i XOR c).

module tb_simplegrev;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;

  logic            clock;
  logic            resetn;
  logic [XLEN-1:0] rs1;
  logic [SHW-1:0]  rs2;
  logic [XLEN-1:0] rd;

  int errs;
  int checks;

  simplegrev #(
    .XLEN (XLEN)
  ) u_dut (
    .clock  (clock),
    .resetn (resetn),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [XLEN-1:0] grev_ref(input logic [XLEN-1:0] a,
                                               input logic [SHW-1:0] c);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = a[i ^ int'(c)];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one operand pair, let one edge capture it, then compare.
  task automatic apply_const(input string tag, input logic [XLEN-1:0] a,
                             input logic [SHW-1:0] c, input logic [XLEN-1:0] exp);
    rs1 = a;
    rs2 = c;
    @(posedge clock);
    #1;
    check(tag, rd, exp);
  endtask

  task automatic apply_model(input string tag, input logic [XLEN-1:0] a,
                             input logic [SHW-1:0] c);
    apply_const(tag, a, c, grev_ref(a, c));
  endtask

  initial begin
    logic [XLEN-1:0] prev_a;
    logic [SHW-1:0]  prev_c;
    logic [XLEN-1:0] a;
    logic [SHW-1:0]  c;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] sweep_vals [2];

    errs   = 0;
    checks = 0;
    rs1    = 32'hDEADBEEF;
    rs2    = 5'h13;
    resetn = 1'b1;

    // Asynchronous reset before any clock edge, inputs nonzero.
    #1 resetn = 1'b0;
    #1 check("reset_async", rd, '0);
    @(posedge clock);
    #1 check("reset_hold", rd, '0);
    @(negedge clock);
    resetn = 1'b1;

    // Directed vectors.
    apply_const("identity", 32'h12345678, 5'h00, 32'h12345678);
    apply_const("rev",      32'h12345678, 5'h1F, 32'h1E6A2C48);
    apply_const("rev8",     32'h12345678, 5'h18, 32'h78563412);
    apply_const("swap16",   32'h12345678, 5'h10, 32'h56781234);
    apply_const("nibswap",  32'h12345678, 5'h04, 32'h21436587);
    apply_const("brev8",    32'h12345678, 5'h07, 32'h482C6A1E);

    // Back-to-back random stream: each edge's result reflects the prior inputs.
    prev_a = $urandom;
    prev_c = 5'($urandom);
    rs1 = prev_a;
    rs2 = prev_c;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clock);
      #1;
      check("stream", rd, grev_ref(prev_a, prev_c));
      prev_a = $urandom;
      prev_c = 5'($urandom);
      rs1 = prev_a;
      rs2 = prev_c;
    end

    // Involution: feed back the result with the same control.
    for (int n = 0; n < 20; n++) begin
      a = $urandom;
      c = 5'($urandom);
      apply_model("invol_fwd", a, c);
      r = rd;
      apply_const("invol_back", r, c, a);
    end

    // Sweep every control value over two operands.
    sweep_vals[0] = 32'hFFFF0000;
    sweep_vals[1] = 32'h80000001;
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 32; k++) begin
        apply_model("sweep", sweep_vals[v], 5'(k));
      end
    end

    // Reset mid-stream: clears without an edge, first edge after release captures.
    rs1 = 32'hA5C3_0F96;
    rs2 = 5'h0B;
    @(posedge clock);
    #1 check("pre_reset", rd, grev_ref(32'hA5C3_0F96, 5'h0B));
    #1 resetn = 1'b0;
    #1 check("reset_mid", rd, '0);
    @(posedge clock);
    #1 check("reset_mid_hold", rd, '0);
    @(negedge clock);
    resetn = 1'b1;
    rs1 = 32'h0123_4567;
    rs2 = 5'h19;
    @(posedge clock);
    #1 check("post_reset", rd, grev_ref(32'h0123_4567, 5'h19));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
